// File: rtl/stall_sched_pkg.sv
// Shared pipeline definitions for the interlock scheduler: default MULT/DIV latencies,
// stall_why bit indices and the zero-register helper used by the hazard terms.
package stall_sched_pkg;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    localparam int STALL_LU = 0;
    localparam int STALL_BR = 1;
    localparam int STALL_MD = 2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic md;
        logic br;
        logic lu;
    } stall_why_t;

    // $0 is hard-wired, so a write to it can never feed a later reader.
    function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
        return (dst != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/stall_sched_md_busy_ctr.sv
// MULT/DIV busy sequencer: loads the unit latency on a start pulse and counts down;
// busy is asserted while the count is nonzero.
module md_busy_ctr
    import stall_sched_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [3:0] L_MULT = 4'(MULT_LAT);
    localparam logic [3:0] L_DIV  = 4'(DIV_LAT);

    logic [3:0] r_cnt;

    // A start seen while already counting is dropped rather than reloading.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (start && (r_cnt == 4'd0)) begin
            r_cnt <= is_div ? L_DIV : L_MULT;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign busy = (r_cnt != 4'd0);

endmodule

// File: rtl/stall_sched.sv
// Pipeline interlock scheduler: load-use, branch/jr operand and MULT/DIV busy stalls.
// Optional stall-cycle counter enabled by defining STALL_COUNT_EN.
module stall_sched
    import stall_sched_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic        b_typeD,
    input  logic        jrD,
    input  logic        cal_rD,
    input  logic        stD,
    input  logic        mdD,
    input  logic        mfD,
    input  logic        mtD,
    input  logic [4:0]  WriteRegE,
    input  logic        cal_rE,
    input  logic        cal_iE,
    input  logic        ldE,
    input  logic        mdE,
    input  logic        divE,
    input  logic [4:0]  WriteRegM,
    input  logic        ldM,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic        md_start,
    output logic        md_busy,
    output logic [2:0]  stall_why,
    output logic [31:0] stall_cnt
);

    logic       w_lu;
    logic       w_br_e;
    logic       w_br_m;
    logic       w_br;
    logic       w_mdh;
    logic       w_stall;
    stall_why_t w_why;

    assign w_lu = ldE & (reg_hit(RsD, WriteRegE)
                  | ((cal_rD | stD | b_typeD) & reg_hit(RtD, WriteRegE)));

    // Branch/jr compare in D, so any producer still in E, or a load still in M, must wait.
    assign w_br_e = (cal_rE | cal_iE | ldE)
                    & (reg_hit(RsD, WriteRegE) | (b_typeD & reg_hit(RtD, WriteRegE)));
    assign w_br_m = ldM & (reg_hit(RsD, WriteRegM) | (b_typeD & reg_hit(RtD, WriteRegM)));
    assign w_br   = (b_typeD | jrD) & (w_br_e | w_br_m);

    assign w_mdh = (mdD | mfD | mtD) & (md_busy | mdE);

    // Nothing is held back while the pipeline is being reset.
    assign w_stall = rst_n & (w_lu | w_br | w_mdh);

    assign w_why.lu = rst_n & w_lu;
    assign w_why.br = rst_n & w_br;
    assign w_why.md = rst_n & w_mdh;

    assign StallF    = w_stall;
    assign StallD    = w_stall;
    assign FlushE    = w_stall;
    assign stall_why = w_why;

    assign md_start = rst_n & mdE & ~md_busy;

    md_busy_ctr #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (divE),
        .busy   (md_busy)
    );

`ifdef STALL_COUNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_stall_sched.sv
// Scoreboard bench for stall_sched: directed pipeline scenarios plus random traffic,
// checked against a cycle-indexed behavioural model of the interlock rules.
module tb_stall_sched;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  RsD, RtD, WriteRegE, WriteRegM;
    logic        b_typeD, jrD, cal_rD, stD, mdD, mfD, mtD;
    logic        cal_rE, cal_iE, ldE, mdE, divE, ldM;
    logic        StallF, StallD, FlushE, md_start, md_busy;
    logic [2:0]  stall_why;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    stall_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .RsD(RsD), .RtD(RtD), .b_typeD(b_typeD), .jrD(jrD),
        .cal_rD(cal_rD), .stD(stD), .mdD(mdD), .mfD(mfD), .mtD(mtD),
        .WriteRegE(WriteRegE), .cal_rE(cal_rE), .cal_iE(cal_iE), .ldE(ldE), .mdE(mdE),
        .divE(divE), .WriteRegM(WriteRegM), .ldM(ldM), .StallF(StallF), .StallD(StallD),
        .FlushE(FlushE), .md_start(md_start), .md_busy(md_busy), .stall_why(stall_why),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt, wre, wrm;
        logic       b, jr, calr, st, md, mf, mt;
        logic       calrE, caliE, ldE, mdE, divE, ldM;
    } stim_t;

    typedef struct {
        logic        stall;
        logic [2:0]  why;
        logic        start;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          tests  = 0;
    int          fails  = 0;
    int          t      = 0;
    int          m_ready = 0;   // first cycle in which the MD unit is no longer busy
    logic [31:0] m_cnt  = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic bit dep(input logic [4:0] src, input logic [4:0] dst);
        return (dst != 5'd0) && (src == dst);
    endfunction

    task automatic apply(input stim_t s, input bit chk);
        exp_t e;
        bit   lu, br, mdh, busy, start;
        rst_n = s.rst; RsD = s.rs; RtD = s.rt; b_typeD = s.b; jrD = s.jr;
        cal_rD = s.calr; stD = s.st; mdD = s.md; mfD = s.mf; mtD = s.mt;
        WriteRegE = s.wre; cal_rE = s.calrE; cal_iE = s.caliE; ldE = s.ldE;
        mdE = s.mdE; divE = s.divE; WriteRegM = s.wrm; ldM = s.ldM;

        busy  = (t < m_ready);
        lu    = s.ldE && (dep(s.rs, s.wre) || ((s.calr || s.st || s.b) && dep(s.rt, s.wre)));
        br    = (s.b || s.jr) &&
                (((s.calrE || s.caliE || s.ldE) && (dep(s.rs, s.wre) || (s.b && dep(s.rt, s.wre))))
                 || (s.ldM && (dep(s.rs, s.wrm) || (s.b && dep(s.rt, s.wrm)))));
        mdh   = (s.md || s.mf || s.mt) && (busy || s.mdE);
        start = s.mdE && !busy;
        if (!s.rst) begin
            lu = 0; br = 0; mdh = 0; start = 0;
        end
        e.stall = lu || br || mdh;
        e.why   = {mdh, br, lu};
        e.start = start;
        e.busy  = busy;
`ifdef STALL_COUNT_EN
        e.cnt   = m_cnt;
`else
        e.cnt   = 32'd0;
`endif
        if (chk) sb_q.push_back(e);

        if (!s.rst) begin
            m_ready = t + 1;
            m_cnt   = 0;
        end else begin
            if (start) m_ready = t + 1 + (s.divE ? DIV_LAT : MULT_LAT);
            if (e.stall) m_cnt = m_cnt + 1;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp("StallF", {31'd0, StallF}, {31'd0, e.stall});
            cmp("StallD", {31'd0, StallD}, {31'd0, e.stall});
            cmp("FlushE", {31'd0, FlushE}, {31'd0, e.stall});
            cmp("stall_why", {29'd0, stall_why}, {29'd0, e.why});
            cmp("md_start", {31'd0, md_start}, {31'd0, e.start});
            cmp("md_busy", {31'd0, md_busy}, {31'd0, e.busy});
            cmp("stall_cnt", stall_cnt, e.cnt);
        end
    end

    initial begin
        stim_t s;
        s = idle();
        s.rst = 1'b0;
        apply(s, 0);
        apply(s, 1);

        // load-use, then the load has moved to M
        s = idle(); s.ldE = 1; s.wre = 8; s.rs = 8; s.rt = 10; s.calr = 1; apply(s, 1);
        s = idle(); s.ldM = 1; s.wrm = 8; s.rs = 8; s.rt = 10; s.calr = 1; apply(s, 1);
        apply(idle(), 1);

        // branch operands: ALU in E, load in M, and $0 never hazards
        s = idle(); s.calrE = 1; s.wre = 8; s.b = 1; s.rs = 8; s.rt = 9; apply(s, 1);
        s = idle(); s.ldM = 1; s.wrm = 9; s.b = 1; s.rs = 8; s.rt = 9; apply(s, 1);
        s = idle(); s.ldE = 1; s.wre = 0; s.rs = 0; s.rt = 0; s.b = 1; s.calr = 1; apply(s, 1);
        s = idle(); s.caliE = 1; s.wre = 7; s.jr = 1; s.rs = 7; apply(s, 1);

        // mult then mflo waiting the full latency
        s = idle(); s.mdE = 1; s.mf = 1; apply(s, 1);
        s = idle(); s.mf = 1;
        for (int i = 0; i < MULT_LAT + 2; i++) apply(s, 1);

        // div aborted by reset on its third busy cycle
        s = idle(); s.mdE = 1; s.divE = 1; apply(s, 1);
        apply(idle(), 1); apply(idle(), 1);
        s = idle(); s.rst = 0; apply(s, 1);
        s = idle(); s.mf = 1; apply(s, 1); apply(s, 1);

        // load-use and MD busy at once on a mult in D
        s = idle(); s.mdE = 1; s.divE = 1; apply(s, 1);
        s = idle(); s.ldE = 1; s.wre = 8; s.md = 1; s.rs = 8; s.rt = 9; apply(s, 1);
        s = idle(); s.md = 1; s.rs = 8; s.rt = 9;
        for (int i = 0; i < DIV_LAT + 1; i++) apply(s, 1);

`ifdef STALL_COUNT_EN
        s = idle(); s.rst = 0; apply(s, 1);
        for (int k = 0; k < 4; k++) begin
            s = idle(); s.ldE = 1; s.wre = 8; s.rs = 8; s.rt = 10; s.calr = 1; apply(s, 1);
            s = idle(); s.ldM = 1; s.wrm = 8; s.rs = 8; s.rt = 10; s.calr = 1; apply(s, 1);
            apply(idle(), 1);
        end
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        m_cnt = 32'hFFFF_FFFF;
        s = idle(); s.ldE = 1; s.wre = 8; s.rs = 8; apply(s, 1);
        apply(idle(), 1);
`endif

        // random traffic over a small register window so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst   = ($urandom_range(0, 99) != 0);
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            s.wre   = 5'($urandom_range(0, 3));
            s.wrm   = 5'($urandom_range(0, 3));
            s.b     = ($urandom_range(0, 3) == 0);
            s.jr    = ($urandom_range(0, 7) == 0);
            s.calr  = ($urandom_range(0, 2) == 0);
            s.st    = ($urandom_range(0, 5) == 0);
            s.md    = ($urandom_range(0, 7) == 0);
            s.mf    = ($urandom_range(0, 3) == 0);
            s.mt    = ($urandom_range(0, 7) == 0);
            s.calrE = ($urandom_range(0, 2) == 0);
            s.caliE = ($urandom_range(0, 3) == 0);
            s.ldE   = ($urandom_range(0, 2) == 0);
            s.mdE   = ($urandom_range(0, 9) == 0);
            s.divE  = $urandom_range(0, 1);
            s.ldM   = ($urandom_range(0, 2) == 0);
            apply(s, 1);
        end

        @(negedge clk);
        #1;
        cmp("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
